// File: rtl/game_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the
// whack-a-mole game logic.
package game_pkg;

  localparam int NUM_MOLES = 18;
  localparam int SCORE_W   = 16;
  // Wide enough to hold a popcount of a full NUM_MOLES word
  localparam int CNT_W     = $clog2(NUM_MOLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETTLE,
    UP,
    GAP
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_MOLES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [CNT_W-1:0]   b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W + 1)'(b);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/mole_limiter.sv
// Turns a random word into the set of moles to light: keeps the lowest
// MAX_ACTIVE set bits, and lights mole 0 when the word is all zeros so a
// round never starts empty.
module mole_limiter
  import game_pkg::*;
#(
  parameter int MAX_ACTIVE = 4
) (
  input  logic [NUM_MOLES-1:0] word,
  output logic [NUM_MOLES-1:0] masked,
  output logic [CNT_W-1:0]     count
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_ACTIVE);

  logic [NUM_MOLES-1:0] kept;

  // Scan from bit 0 upward, accepting set bits until LIMIT have been taken
  always_comb begin
    logic [CNT_W-1:0] seen;
    seen = '0;
    kept = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      if (word[i] && (seen < LIMIT)) begin
        kept[i] = 1'b1;
        seen    = seen + 1'b1;
      end
    end
  end

  assign masked = (word == '0) ? {{(NUM_MOLES-1){1'b0}}, 1'b1} : kept;
  assign count  = popcount(masked);

endmodule

// File: rtl/mole_spawner.sv
// Round sequencer for the mole game: requests a random word, lights the
// limited set of moles, scores synchronized switch edges against them and
// pauses between rounds.
module mole_spawner
  import game_pkg::*;
#(
  parameter int UP_CYCLES  = 50000000,
  parameter int GAP_CYCLES = 12500000,
  parameter int MAX_ACTIVE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] rand_value,
  input  logic [NUM_MOLES-1:0] hit_in,
  output logic                 rand_change,
  output logic [NUM_MOLES-1:0] leds,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 round_done
);

  localparam int MAX_CYCLES = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] UP_LOAD  = TIMER_W'(UP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic                 start_prev;
  logic [CNT_W-1:0]     moles_left;
  logic [NUM_MOLES-1:0] hit_sync1;
  logic [NUM_MOLES-1:0] hit_sync2;
  logic [NUM_MOLES-1:0] hit_prev;

  logic [NUM_MOLES-1:0] hit_event;
  logic [NUM_MOLES-1:0] limit_word;
  logic [CNT_W-1:0]     limit_count;
  logic [CNT_W-1:0]     good_cnt;
  logic [CNT_W-1:0]     wrong_cnt;
  logic [CNT_W-1:0]     expire_cnt;

  mole_limiter #(
    .MAX_ACTIVE(MAX_ACTIVE)
  ) u_limiter (
    .word  (rand_value),
    .masked(limit_word),
    .count (limit_count)
  );

  // A hit is a synchronized 0->1 edge on a switch; no debounce on purpose
  assign hit_event = hit_sync2 & ~hit_prev;
  assign good_cnt  = popcount(hit_event & leds);
  assign wrong_cnt = popcount(hit_event & ~leds);
  // On timeout the wrong hits and the still-lit moles are disjoint sets,
  // so one popcount of the XOR gives their combined miss count
  assign expire_cnt = popcount(hit_event ^ leds);

  // Two-flop synchronizer followed by the edge-detect history register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_sync1 <= '0;
      hit_sync2 <= '0;
      hit_prev  <= '0;
    end else begin
      hit_sync1 <= hit_in;
      hit_sync2 <= hit_sync1;
      hit_prev  <= hit_sync2;
    end
  end

  // Round FSM with registered outputs and shared up/gap timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      start_prev  <= 1'b0;
      moles_left  <= '0;
      leds        <= '0;
      score       <= '0;
      misses      <= '0;
      rand_change <= 1'b0;
      round_done  <= 1'b0;
    end else begin
      start_prev  <= start;
      rand_change <= 1'b0;
      round_done  <= 1'b0;
      if ((state != IDLE) && !start) begin
        // Game abandoned: go dark but keep the tallies on display
        state <= IDLE;
        leds  <= '0;
      end else begin
        case (state)
          IDLE: begin
            leds <= '0;
            if (start && !start_prev) begin
              score       <= '0;
              misses      <= '0;
              rand_change <= 1'b1;
              state       <= REQ;
            end
          end
          REQ: begin
            state <= SETTLE;
          end
          SETTLE: begin
            leds       <= limit_word;
            moles_left <= limit_count;
            timer      <= UP_LOAD;
            state      <= UP;
          end
          UP: begin
            score <= sat_add(score, good_cnt);
            if (good_cnt == moles_left) begin
              // Every lit mole was whacked: end the round early
              misses     <= sat_add(misses, wrong_cnt);
              leds       <= '0;
              round_done <= 1'b1;
              timer      <= GAP_LOAD;
              state      <= GAP;
            end else if (timer == '0) begin
              misses     <= sat_add(misses, expire_cnt);
              leds       <= '0;
              round_done <= 1'b1;
              timer      <= GAP_LOAD;
              state      <= GAP;
            end else begin
              misses     <= sat_add(misses, wrong_cnt);
              leds       <= leds & ~hit_event;
              moles_left <= moles_left - good_cnt;
              timer      <= timer - 1'b1;
            end
          end
          GAP: begin
            leds <= '0;
            if (timer == '0) begin
              // start is known high here; a low start was handled above
              rand_change <= 1'b1;
              state       <= REQ;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            leds  <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Downstream consumer of the game's 18-bit random number generator; turns each random word into a set of lit "moles" on LEDR[17:0].
- Requests a fresh random word per round via a one-cycle change pulse, shows moles for a fixed up-time, scores player hits from raw (non-debounced) switches, then waits a gap before the next round.
- Sits between the rng and the score/7-segment display logic.

Parameters:
- NUM_MOLES, 18, number of LED/switch positions; fixed to match the rng word width.
- UP_CYCLES, 50000000, clock cycles the moles stay lit per round (1 s at 50 MHz).
- GAP_CYCLES, 12500000, dark cycles between rounds.
- MAX_ACTIVE, 4, maximum moles lit simultaneously (1..NUM_MOLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  game enable level; a rising edge starts a new game.
- rand_value  input  18  random word from rng.
- hit_in  input  18  raw player switches, asynchronous to clk.
- rand_change  output  1  rng advance request, high exactly one cycle per round.
- leds  output  18  currently lit moles.
- score  output  16  count of moles hit, saturating.
- misses  output  16  moles expired unhit plus wrong hits, saturating.
- round_done  output  1  one-cycle pulse when a round ends.

Behaviour:
- Reset (reset=0, async): state IDLE; leds=0, score=0, misses=0, rand_change=0, round_done=0, timer=0, synchronizers and edge registers=0.
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on port reset.
- States: IDLE, REQ, SETTLE, UP, GAP. All outputs are registered or decoded from the state register only.
- IDLE:
  - leds=0.
  - On a start rising edge (start=1, previous start=0): clear score and misses, go to REQ.
- REQ: rand_change=1 for this single cycle; next state SETTLE.
- SETTLE:
  - The rng has updated rand_value at the edge that ended REQ.
  - At the edge ending SETTLE, load leds = limit(rand_value), load timer=UP_CYCLES-1, go to UP.
- limit() rules:
  - Keep only the lowest MAX_ACTIVE set bits of rand_value.
  - If rand_value==0, result is 18'h00001.
- hit_in conditioning:
  - Each bit passes through a 2-flop synchronizer, then a rising-edge detector (no debounce).
  - Hit event = synchronized 0→1 transition. Latency from hit_in to the event is 3 clk edges.
- UP, per cycle, with hit events h:
  - leds <= leds & ~h.
  - score += popcount(h & leds).
  - misses += popcount(h & ~leds).
  - Multiple simultaneous events are all counted in the same cycle.
- UP exit:
  - If leds & ~h == 0 (all moles hit): round_done=1, timer=GAP_CYCLES-1, go to GAP.
  - Else if timer==0: misses += popcount(leds & ~h), leds <= 0, round_done=1, go to GAP. A hit in the timeout cycle still scores.
  - Else timer decrements.
- GAP:
  - leds=0; hit events in GAP are ignored (not counted).
  - When timer==0: go to REQ if start=1, else IDLE.
- start low in any state other than IDLE: next edge → IDLE, leds=0, score and misses held (display keeps final result).
- Saturation: score and misses clamp at 16'hFFFF and do not wrap.
- Timer width: clog2 of max(UP_CYCLES, GAP_CYCLES).
- Reset mid-round: immediate return to the reset values; no rand_change is emitted.

Decomposition:
- Shared package game_pkg:
  - NUM_MOLES = 18.
  - State enum encoding (IDLE, REQ, SETTLE, UP, GAP).
  - Saturating-add width constant SCORE_W = 16.
- Sub-module mole_limiter:
  - Combinational; parameter MAX_ACTIVE.
  - Input 18-bit word; outputs the masked 18-bit word and its popcount.
  - Keeps the lowest MAX_ACTIVE set bits and forces bit 0 when the input is zero.
- Instantiated once; popcount also reused for hit/miss tallies.

Test Plan:
- Reset then start rising edge:
  - Response: rand_change high exactly 1 cycle, 2 cycles after the start edge is seen.
  - Stub rand_value=18'h0000F with MAX_ACTIVE=4: leds=18'h0000F in UP.
- rand_value=18'h3FFFF, MAX_ACTIVE=4 → leds=18'h0000F; rand_value=0 → leds=18'h00001.
- UP_CYCLES=10, leds=18'h00005, raise hit_in[0] → 3 edges later leds=18'h00004, score=1; no further hits → at timeout misses=1, leds=0, round_done pulse.
- leds=18'h00003, hit_in[1:0] rise same cycle → score+=2, immediate round_done, GAP entered before timer expiry.
- hit_in[5] rising while leds=18'h00001 → misses=1, leds unchanged; hit_in toggling during GAP → no counter change.
- score preset to 16'hFFFE, two simultaneous hits → score=16'hFFFF. Deassert start in UP → IDLE, leds=0, score held. Assert reset mid-UP → all outputs 0 immediately.
